icache_tag_array: RTL and testbench

Instruction-cache tag and valid-bit store. It serves the tag-read requests issued by instruction fetch stage 1 and returns per-way tags and valid bits one cycle later to fetch stage 2. It accepts line fills from the I-cache miss handler and performs whole-cache invalidation, both of which are serialized against reads through the `o_avail` handshake. On reset it sweeps every set to invalid before offering service.

---
 rtl/icache_tag_array.sv | 171 +++++++++++++++++
 tb/tb_icache_tag_array.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_tag_array.sv
// Instruction-cache tag/valid store: one-cycle tag reads for fetch,
// line fills and whole-cache invalidate serialized behind o_avail.
module icache_tag_array #(
    parameter int NUM_SETS  = 64,
    parameter int NUM_WAYS  = 2,
    parameter int TAG_WIDTH = 20,
    parameter int PC_WIDTH  = 32,
    parameter int INDEX_LSB = 6
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_read,
    input  logic [PC_WIDTH-1:0]           i_pc,
    output logic                          o_avail,
    output logic                          o_resp_valid,
    output logic [NUM_WAYS*TAG_WIDTH-1:0] o_resp_tags,
    output logic [NUM_WAYS-1:0]           o_resp_way_valid,
    input  logic                          i_fill,
    input  logic [PC_WIDTH-1:0]           i_fill_pc,
    input  logic [$clog2(NUM_WAYS)-1:0]   i_fill_way,
    input  logic                          i_inv_all,
    output logic                          o_inv_done,
    input  logic [31:0]                   i_log_fd
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_LSB = INDEX_LSB + IDX_W;

    typedef enum logic [1:0] {
        S_INIT,
        S_READY,
        S_INV
    } state_e;

    state_e state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic inv_pend_q, inv_pend_d;

    logic resp_valid_q, resp_valid_d;
    logic [NUM_WAYS*TAG_WIDTH-1:0] resp_tags_q, resp_tags_d;
    logic [NUM_WAYS-1:0] resp_way_valid_q, resp_way_valid_d;

    logic [TAG_WIDTH-1:0] tag_q [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_WIDTH-1:0] fill_tag;
    logic sweep_last;
    logic sweep_en;
    logic fill_en;
    logic read_acc;
    logic fill_way_ok;

    assign rd_idx = i_pc[INDEX_LSB +: IDX_W];
    assign fill_idx = i_fill_pc[INDEX_LSB +: IDX_W];
    assign fill_tag = i_fill_pc[TAG_LSB +: TAG_WIDTH];
    assign fill_way_ok = int'(i_fill_way) < NUM_WAYS;
    assign sweep_last = sweep_idx_q == IDX_W'(NUM_SETS - 1);

    always_comb begin
        o_avail = (state_q == S_READY) & ~i_fill & ~i_inv_all;
        read_acc = i_read & o_avail;
        sweep_en = i_rst_n & (state_q != S_READY);
        fill_en = i_rst_n & (state_q == S_READY) & i_fill
                  & ~i_inv_all & fill_way_ok;
        // An invalidate seen during INIT is folded into the init sweep.
        o_inv_done = sweep_last
                     & ((state_q == S_INV)
                        | ((state_q == S_INIT) & (inv_pend_q | i_inv_all)));
    end

    always_comb begin
        state_d = state_q;
        sweep_idx_d = sweep_idx_q;
        inv_pend_d = inv_pend_q;
        unique case (state_q)
            S_INIT: begin
                sweep_idx_d = sweep_idx_q + IDX_W'(1);
                if (i_inv_all) begin
                    inv_pend_d = 1'b1;
                end
                if (sweep_last) begin
                    state_d = S_READY;
                    sweep_idx_d = '0;
                    inv_pend_d = 1'b0;
                end
            end
            S_INV: begin
                sweep_idx_d = sweep_idx_q + IDX_W'(1);
                if (sweep_last) begin
                    state_d = S_READY;
                    sweep_idx_d = '0;
                end
            end
            S_READY: begin
                if (i_inv_all) begin
                    state_d = S_INV;
                    sweep_idx_d = '0;
                end
            end
            default: begin
                state_d = S_INIT;
                sweep_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        resp_valid_d = read_acc;
        resp_tags_d = resp_tags_q;
        resp_way_valid_d = resp_way_valid_q;
        if (read_acc) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                resp_tags_d[w*TAG_WIDTH +: TAG_WIDTH] = tag_q[rd_idx][w];
            end
            resp_way_valid_d = valid_q[rd_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_INIT;
            sweep_idx_q <= '0;
            inv_pend_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_tags_q <= '0;
            resp_way_valid_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_idx_q <= sweep_idx_d;
            inv_pend_q <= inv_pend_d;
            resp_valid_q <= resp_valid_d;
            resp_tags_q <= resp_tags_d;
            resp_way_valid_q <= resp_way_valid_d;
        end
    end

    // Tags are never cleared; only valid bits are swept.
    always_ff @(posedge i_clk) begin
        if (sweep_en) begin
            valid_q[sweep_idx_q] <= '0;
        end
        if (fill_en) begin
            valid_q[fill_idx][i_fill_way] <= 1'b1;
            tag_q[fill_idx][i_fill_way] <= fill_tag;
        end
    end

    assign o_resp_valid = resp_valid_q;
    assign o_resp_tags = resp_tags_q;
    assign o_resp_way_valid = resp_way_valid_q;

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_log_fd != 32'd0) begin
            if (read_acc) begin
                $display("[ITAG] read pc=%h set=%0d", i_pc, rd_idx);
            end
            if (fill_en) begin
                $display("[ITAG] fill pc=%h set=%0d way=%0d",
                         i_fill_pc, fill_idx, i_fill_way);
            end
            if (sweep_en && sweep_last) begin
                $display("[ITAG] sweep done inv=%0d", o_inv_done);
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_tag_array.sv
// Self-checking bench for icache_tag_array: directed table, corner
// sequences and random traffic against a set/way array model.
module tb_icache_tag_array;

    localparam int NS = 64;
    localparam int NW = 2;
    localparam int TW = 20;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_read = 1'b0;
    logic [31:0] i_pc = '0;
    logic o_avail;
    logic o_resp_valid;
    logic [NW*TW-1:0] o_resp_tags;
    logic [NW-1:0] o_resp_way_valid;
    logic i_fill = 1'b0;
    logic [31:0] i_fill_pc = '0;
    logic [0:0] i_fill_way = '0;
    logic i_inv_all = 1'b0;
    logic o_inv_done;
    logic [31:0] i_log_fd = '0;

    icache_tag_array dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_read(i_read),
        .i_pc(i_pc),
        .o_avail(o_avail),
        .o_resp_valid(o_resp_valid),
        .o_resp_tags(o_resp_tags),
        .o_resp_way_valid(o_resp_way_valid),
        .i_fill(i_fill),
        .i_fill_pc(i_fill_pc),
        .i_fill_way(i_fill_way),
        .i_inv_all(i_inv_all),
        .o_inv_done(o_inv_done),
        .i_log_fd(i_log_fd)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;

    // Reference model: plain arrays plus a "cycles of sweep left" counter.
    bit [TW-1:0] mtag [NS][NW];
    bit mvalid [NS][NW];
    bit mknown [NS][NW];
    int busy = NS;
    bit inv_mode = 0;
    bit pend = 0;
    bit m_init = 0;
    bit m_rv = 0;
    bit [TW-1:0] m_rt [NW];
    bit m_rk [NW];
    logic [NW-1:0] m_rwv = '0;

    logic s_avail, s_done, s_rv;
    logic [NW-1:0] s_wv;
    logic [NW*TW-1:0] s_tags;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cyc_n, got, exp);
        end
    endtask

    task automatic cyc(input bit rd, input logic [31:0] pc, input bit fl,
                       input logic [31:0] fpc, input bit way, input bit inv,
                       input bit rst);
        bit e_avail, e_done, acc;
        int set;
        @(negedge i_clk);
        i_read = rd;
        i_pc = pc;
        i_fill = fl;
        i_fill_pc = fpc;
        i_fill_way = way;
        i_inv_all = inv;
        i_rst_n = rst;
        #1;
        s_avail = o_avail;
        s_done = o_inv_done;
        s_rv = o_resp_valid;
        s_wv = o_resp_way_valid;
        s_tags = o_resp_tags;
        cyc_n++;
        if (!rst) begin
            busy = NS;
            pend = 0;
            inv_mode = 0;
            m_rv = 0;
            m_rwv = '0;
            for (int w = 0; w < NW; w++) begin
                m_rt[w] = '0;
                m_rk[w] = 1;
            end
            m_init = 1;
            return;
        end
        if (!m_init) return;
        e_avail = (busy == 0) && !fl && !inv;
        e_done = (busy == 1) && (inv_mode || pend || inv);
        chk("avail", s_avail, e_avail);
        chk("inv_done", s_done, e_done);
        chk("resp_valid", s_rv, m_rv);
        chk("way_valid", s_wv, m_rwv);
        for (int w = 0; w < NW; w++) begin
            if (m_rk[w]) chk("resp_tag", s_tags[w*TW +: TW], m_rt[w]);
        end
        acc = rd && e_avail;
        if (acc) begin
            set = int'(pc[11:6]);
            for (int w = 0; w < NW; w++) begin
                m_rt[w] = mtag[set][w];
                m_rk[w] = mknown[set][w];
                m_rwv[w] = mvalid[set][w];
            end
        end
        m_rv = acc;
        if (busy > 0) begin
            for (int w = 0; w < NW; w++) mvalid[NS-busy][w] = 0;
            if (!inv_mode && inv) pend = 1;
            busy--;
            if (busy == 0) begin
                pend = 0;
                inv_mode = 0;
            end
        end else if (inv) begin
            busy = NS;
            inv_mode = 1;
        end else if (fl) begin
            set = int'(fpc[11:6]);
            mtag[set][way] = fpc[31:12];
            mvalid[set][way] = 1;
            mknown[set][way] = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic wait_ready(output int low, output int dones);
        low = 0;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            if (s_done) dones++;
            if (s_avail) break;
            low++;
        end
    endtask

    task automatic read_wv(input logic [31:0] pc, input string nm,
                           input logic [NW-1:0] exp);
        cyc(1, pc, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk({nm, "_rv"}, s_rv, 1'b1);
        chk({nm, "_wv"}, s_wv, exp);
    endtask

    typedef struct {
        bit rd;
        logic [31:0] pc;
        bit fl;
        logic [31:0] fpc;
        bit way;
        bit inv;
        bit e_avail;
        bit e_rv;
        logic [1:0] e_wv;
        bit chk_t1;
        logic [19:0] e_t1;
    } vec_t;

    vec_t tv [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d", cyc_n);
        $fatal(1, "timeout");
    end

    initial begin
        int low, dones, tot;
        logic [31:0] rpc, fpc;

        tv[0] = '{1, 32'h0000_1040, 0, 32'h0, 0, 0, 1, 0, 2'b00, 0, 20'h0};
        tv[1] = '{0, 32'h0, 1, 32'h1234_5680, 1, 0, 0, 1, 2'b00, 0, 20'h0};
        tv[2] = '{1, 32'h1234_5680, 0, 32'h0, 0, 0, 1, 0, 2'b00, 0, 20'h0};
        tv[3] = '{0, 32'h0, 0, 32'h0, 0, 0, 1, 1, 2'b10, 1, 20'h12345};
        tv[4] = '{1, 32'h0000_0A40, 1, 32'h0000_0A40, 0, 0,
                  0, 0, 2'b10, 1, 20'h12345};
        tv[5] = '{0, 32'h0, 0, 32'h0, 0, 0, 1, 0, 2'b10, 0, 20'h0};
        tv[6] = '{1, 32'h0000_0A40, 0, 32'h0, 0, 0, 1, 0, 2'b10, 0, 20'h0};
        tv[7] = '{0, 32'h0, 0, 32'h0, 0, 0, 1, 1, 2'b01, 0, 20'h0};

        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        wait_ready(low, dones);
        chk("init_len", low, 64);
        chk("init_dones", dones, 0);
        chk("init_tags", s_tags, 0);

        for (int i = 0; i < 8; i++) begin
            cyc(tv[i].rd, tv[i].pc, tv[i].fl, tv[i].fpc, tv[i].way,
                tv[i].inv, 1);
            chk("tv_avail", s_avail, tv[i].e_avail);
            chk("tv_rv", s_rv, tv[i].e_rv);
            chk("tv_wv", s_wv, tv[i].e_wv);
            if (tv[i].chk_t1) chk("tv_tag1", s_tags[TW +: TW], tv[i].e_t1);
        end

        cyc(0, 0, 1, 32'hABCD_E000, 0, 0, 1);
        cyc(0, 0, 1, 32'hABCD_E140, 1, 0, 1);
        cyc(0, 0, 1, 32'hABCD_EFC0, 0, 0, 1);
        read_wv(32'hABCD_E140, "pre_inv", 2'b10);
        cyc(0, 0, 0, 0, 0, 1, 1);
        wait_ready(low, dones);
        chk("inv_len", low + 1, 65);
        chk("inv_dones", dones, 1);
        read_wv(32'hABCD_E000, "inv_s0", 2'b00);
        read_wv(32'hABCD_E140, "inv_s5", 2'b00);
        read_wv(32'hABCD_EFC0, "inv_s63", 2'b00);

        cyc(0, 0, 1, 32'h5555_51C0, 1, 1, 1);
        chk("invfill_avail", s_avail, 1'b0);
        wait_ready(low, dones);
        chk("invfill_dones", dones, 1);
        read_wv(32'h5555_51C0, "invfill", 2'b00);

        cyc(0, 0, 0, 0, 0, 1, 1);
        tot = 1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            tot += s_avail ? 0 : 1;
            dones += s_done ? 1 : 0;
        end
        cyc(0, 0, 0, 0, 0, 1, 1);
        tot += s_avail ? 0 : 1;
        dones += s_done ? 1 : 0;
        wait_ready(low, tot);
        chk("inv_absorb_len", low + 22, 65);
        chk("inv_absorb_dones", dones + tot, 1);

        cyc(0, 0, 0, 0, 0, 0, 0);
        idle(30);
        cyc(0, 0, 0, 0, 0, 0, 0);
        wait_ready(low, dones);
        chk("rst_mid_len", low, 64);
        chk("rst_mid_rv", s_rv, 1'b0);
        chk("rst_mid_wv", s_wv, 2'b00);
        chk("rst_mid_tags", s_tags, 0);

        cyc(0, 0, 0, 0, 0, 0, 0);
        idle(10);
        cyc(0, 0, 0, 0, 0, 1, 1);
        wait_ready(low, dones);
        chk("init_inv_len", low, 53);
        chk("init_inv_dones", dones, 1);

        for (int i = 0; i < 4000; i++) begin
            bit rd, fl, inv, rst, way;
            rpc = {$urandom_range(0, 3) == 0 ? 20'hFEED0 : 20'($urandom_range(0, 3)),
                   6'($urandom_range(0, 15)), 6'($urandom)};
            fpc = {20'($urandom_range(0, 3)), 6'($urandom_range(0, 15)),
                   6'($urandom)};
            rd = $urandom_range(0, 9) < 7;
            fl = $urandom_range(0, 9) < 2;
            way = 1'($urandom);
            inv = $urandom_range(0, 199) == 0;
            rst = $urandom_range(0, 799) != 0;
            cyc(rd, rpc, fl, fpc, way, inv, rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
